// File: rtl/qu_rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, out-of-order writeback, in-order retire.
// Optional pipeline flush on mispredicted commit is enabled by defining QU_ROB_FLUSH_EN.
module qu_rob_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   output logic [ADDR_W-1:0] alloc_addr,
   input  logic [31:0]       alloc_dest,
   input  logic              alloc_store,
   input  logic              alloc_load,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              wb_mispredict,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [DATA_W-1:0] commit_value,
   output logic [31:0]       commit_dest,
   output logic              commit_store,
   output logic              commit_load,
   output logic              commit_mispredict,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              flush
);

   typedef enum logic [1:0] {
      CELL_EMPTY   = 2'b00,
      CELL_RETIRED = 2'b01,
      CELL_EXECUTE = 2'b10,
      CELL_PENDING = 2'b11
   } cell_state_t;

   cell_state_t       state_reg  [DEPTH];
   cell_state_t       state_next [DEPTH];
   logic [DATA_W-1:0] value_reg  [DEPTH];
   logic [DATA_W-1:0] value_next [DEPTH];
   logic [31:0]       dest_reg   [DEPTH];
   logic [31:0]       dest_next  [DEPTH];
   logic [DEPTH-1:0]  store_reg, store_next;
   logic [DEPTH-1:0]  load_reg, load_next;
   logic [DEPTH-1:0]  misp_reg, misp_next;
   logic [DEPTH-1:0]  cell_pending;

   logic [ADDR_W-1:0] head_reg, head_next;
   logic [ADDR_W-1:0] tail_reg, tail_next;
   logic [ADDR_W:0]   count_reg, count_next;

   logic alloc_fire;
   logic commit_fire;
   logic flush_fire;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
         assign cell_pending[gi] = (state_reg[gi] == CELL_PENDING);
      end
   endgenerate

   assign full        = (count_reg == (ADDR_W+1)'(DEPTH));
   assign empty       = (count_reg == '0);
   assign count       = count_reg;
   assign alloc_ready = !full;
   assign alloc_addr  = tail_reg;
   assign alloc_fire  = alloc_valid && alloc_ready;

   // Head view is combinational from the registered array; zeroed when nothing is retirable.
   assign commit_valid      = !empty && (state_reg[head_reg] == CELL_EXECUTE);
   assign commit_value      = commit_valid ? value_reg[head_reg] : '0;
   assign commit_dest       = commit_valid ? dest_reg[head_reg]  : '0;
   assign commit_store      = commit_valid && store_reg[head_reg];
   assign commit_load       = commit_valid && load_reg[head_reg];
   assign commit_mispredict = commit_valid && misp_reg[head_reg];
   assign commit_fire       = commit_valid && commit_ready;

`ifdef QU_ROB_FLUSH_EN
   logic flush_reg;
   assign flush_fire = commit_fire && commit_mispredict;
   assign flush      = flush_reg;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         flush_reg <= 1'b0;
      end else begin
         flush_reg <= flush_fire;
      end
   end
`else
   assign flush_fire = 1'b0;
   assign flush      = 1'b0;
`endif

   // Allocation only ever targets an EMPTY/RETIRED tail cell and commit only an EXECUTE
   // head cell, so the per-cell update priorities below never actually collide.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         state_next[i] = state_reg[i];
         value_next[i] = value_reg[i];
         dest_next[i]  = dest_reg[i];
      end
      store_next = store_reg;
      load_next  = load_reg;
      misp_next  = misp_reg;

      for (int i = 0; i < DEPTH; i++) begin
         if (flush_fire) begin
            state_next[i] = CELL_EMPTY;
            value_next[i] = '0;
            dest_next[i]  = '0;
            store_next[i] = 1'b0;
            load_next[i]  = 1'b0;
            misp_next[i]  = 1'b0;
         end else if (alloc_fire && (tail_reg == ADDR_W'(i))) begin
            state_next[i] = CELL_PENDING;
            value_next[i] = '0;
            dest_next[i]  = alloc_dest;
            store_next[i] = alloc_store;
            load_next[i]  = alloc_load;
            misp_next[i]  = 1'b0;
         end else if (wb_valid && (wb_addr == ADDR_W'(i)) && cell_pending[i]) begin
            state_next[i] = CELL_EXECUTE;
            value_next[i] = wb_value;
            misp_next[i]  = wb_mispredict;
         end else if (commit_fire && (head_reg == ADDR_W'(i))) begin
            state_next[i] = CELL_RETIRED;
         end
      end
   end

   // Pointer wrap is the natural binary rollover since DEPTH is a power of two.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush_fire) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (commit_fire) head_next = head_reg + 1'b1;
         if (alloc_fire)  tail_next = tail_reg + 1'b1;
         case ({alloc_fire, commit_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_reg[i] <= CELL_EMPTY;
            value_reg[i] <= '0;
            dest_reg[i]  <= '0;
         end
         store_reg <= '0;
         load_reg  <= '0;
         misp_reg  <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            state_reg[i] <= state_next[i];
            value_reg[i] <= value_next[i];
            dest_reg[i]  <= dest_next[i];
         end
         store_reg <= store_next;
         load_reg  <= load_next;
         misp_reg  <= misp_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_qu_rob_ctrl.sv
// Directed self-checking bench for qu_rob_ctrl (DEPTH=8); expectations follow QU_ROB_FLUSH_EN.
module tb_qu_rob_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [2:0]  alloc_addr;
   logic [31:0] alloc_dest;
   logic        alloc_store;
   logic        alloc_load;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [31:0] wb_value;
   logic        wb_mispredict;
   logic        commit_valid;
   logic        commit_ready;
   logic [31:0] commit_value;
   logic [31:0] commit_dest;
   logic        commit_store;
   logic        commit_load;
   logic        commit_mispredict;
   logic [3:0]  count;
   logic        empty;
   logic        full;
   logic        flush;

   int total = 0;
   int bad   = 0;

   qu_rob_ctrl #(.DEPTH(8), .ADDR_W(3), .DATA_W(32)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .alloc_valid       (alloc_valid),
      .alloc_ready       (alloc_ready),
      .alloc_addr        (alloc_addr),
      .alloc_dest        (alloc_dest),
      .alloc_store       (alloc_store),
      .alloc_load        (alloc_load),
      .wb_valid          (wb_valid),
      .wb_addr           (wb_addr),
      .wb_value          (wb_value),
      .wb_mispredict     (wb_mispredict),
      .commit_valid      (commit_valid),
      .commit_ready      (commit_ready),
      .commit_value      (commit_value),
      .commit_dest       (commit_dest),
      .commit_store      (commit_store),
      .commit_load       (commit_load),
      .commit_mispredict (commit_mispredict),
      .count             (count),
      .empty             (empty),
      .full              (full),
      .flush             (flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid   = 1'b0;
      alloc_dest    = 32'h0;
      alloc_store   = 1'b0;
      alloc_load    = 1'b0;
      wb_valid      = 1'b0;
      wb_addr       = 3'd0;
      wb_value      = 32'h0;
      wb_mispredict = 1'b0;
      commit_ready  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic do_alloc(input logic [31:0] dest);
      alloc_valid = 1'b1;
      alloc_dest  = dest;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_wb(input logic [2:0] addr, input logic [31:0] val, input logic misp);
      wb_valid      = 1'b1;
      wb_addr       = addr;
      wb_value      = val;
      wb_mispredict = misp;
      tick();
      wb_valid      = 1'b0;
      wb_mispredict = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
      total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL reset_alloc_addr got=%0d exp=0", alloc_addr); end
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
      total++; if (commit_dest !== 32'h0) begin bad++; $display("FAIL reset_commit_dest got=%h exp=0", commit_dest); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", flush); end
      $display("test_reset: empty=%0b count=%0d alloc_addr=%0d", empty, count, alloc_addr);
   endtask

   task automatic test_fill_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         total++; if (alloc_addr !== 3'(i)) begin bad++; $display("FAIL fill_addr%0d got=%0d exp=%0d", i, alloc_addr, i); end
         do_alloc(32'h10 + 32'(i));
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", full); end
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", alloc_ready); end
      do_alloc(32'h99);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_9th_count got=%0d exp=8", count); end
      total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL fill_9th_tail got=%0d exp=0", alloc_addr); end
      for (int i = 7; i >= 1; i--) do_wb(3'(i), 32'h100 + 32'(i), 1'b0);
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL fill_head_pending got=%0b exp=0", commit_valid); end
      do_wb(3'd0, 32'h100, 1'b0);
      commit_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            alloc_valid = 1'b1;
            alloc_dest  = 32'h18;
            total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL wrap_alloc_addr got=%0d exp=0", alloc_addr); end
         end
         total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL commit%0d_valid got=%0b exp=1", i, commit_valid); end
         total++; if (commit_dest !== 32'h10 + 32'(i)) begin bad++; $display("FAIL commit%0d_dest got=%h exp=%h", i, commit_dest, 32'h10 + 32'(i)); end
         total++; if (commit_value !== 32'h100 + 32'(i)) begin bad++; $display("FAIL commit%0d_value got=%h exp=%h", i, commit_value, 32'h100 + 32'(i)); end
         $display("test_fill_wrap: commit %0d dest=%h value=%h", i, commit_dest, commit_value);
         tick();
         alloc_valid = 1'b0;
      end
      commit_ready = 1'b0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL wrap_final_count got=%0d exp=1", count); end
      total++; if (alloc_addr !== 3'd1) begin bad++; $display("FAIL wrap_final_tail got=%0d exp=1", alloc_addr); end
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL wrap_final_valid got=%0b exp=0", commit_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      alloc_store = 1'b1;
      do_alloc(32'h55);
      alloc_store = 1'b0;
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL bp_lat_pending got=%0b exp=0", commit_valid); end
      do_wb(3'd0, 32'hCAFE, 1'b0);
      for (int k = 0; k < 3; k++) begin
         total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got=%0b exp=1", k, commit_valid); end
         total++; if (count !== 4'd1) begin bad++; $display("FAIL bp%0d_count got=%0d exp=1", k, count); end
         total++; if (commit_value !== 32'hCAFE) begin bad++; $display("FAIL bp%0d_value got=%h exp=cafe", k, commit_value); end
         total++; if (commit_store !== 1'b1 || commit_dest !== 32'h55) begin bad++; $display("FAIL bp%0d_meta got=%0b/%h exp=1/55", k, commit_store, commit_dest); end
         $display("test_backpressure: cycle %0d valid=%0b value=%h", k, commit_valid, commit_value);
         if (k == 1) do_wb(3'd0, 32'hBAD, 1'b1);
         else tick();
      end
      commit_ready = 1'b1;
      tick();
      commit_ready = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL bp_drain_empty got=%0b exp=1", empty); end
      total++; if (commit_valid !== 1'b0 || commit_value !== 32'h0) begin bad++; $display("FAIL bp_drain_outputs got=%0b/%h exp=0/0", commit_valid, commit_value); end
   endtask

   task automatic test_alloc_commit();
      do_reset();
      for (int i = 0; i < 5; i++) do_alloc(32'h20 + 32'(i));
      do_wb(3'd0, 32'h200, 1'b0);
      total++; if (count !== 4'd5) begin bad++; $display("FAIL ac_pre_count got=%0d exp=5", count); end
      alloc_valid  = 1'b1;
      alloc_dest   = 32'h30;
      commit_ready = 1'b1;
      total++; if (alloc_addr !== 3'd5) begin bad++; $display("FAIL ac_alloc_addr got=%0d exp=5", alloc_addr); end
      tick();
      alloc_valid  = 1'b0;
      commit_ready = 1'b0;
      total++; if (count !== 4'd5) begin bad++; $display("FAIL ac_count got=%0d exp=5", count); end
      total++; if (alloc_addr !== 3'd6) begin bad++; $display("FAIL ac_tail got=%0d exp=6", alloc_addr); end
      do_wb(3'd1, 32'h201, 1'b0);
      total++; if (commit_dest !== 32'h21) begin bad++; $display("FAIL ac_head got=%h exp=21", commit_dest); end
      $display("test_alloc_commit: count=%0d tail=%0d head_dest=%h", count, alloc_addr, commit_dest);
   endtask

   task automatic test_stray_wb();
      do_reset();
      do_wb(3'd3, 32'hDEAD, 1'b0);
      total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL stray_count got=%0d exp=0", count); end
      for (int i = 0; i < 4; i++) do_alloc(32'h60 + 32'(i));
      for (int i = 0; i < 3; i++) do_wb(3'(i), 32'h70 + 32'(i), 1'b0);
      commit_ready = 1'b1;
      tick(); tick(); tick();
      commit_ready = 1'b0;
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL stray_slot_pending got=%0b exp=0", commit_valid); end
      total++; if (commit_value !== 32'h0) begin bad++; $display("FAIL stray_slot_value got=%h exp=0", commit_value); end
      do_wb(3'd3, 32'h33, 1'b0);
      total++; if (commit_value !== 32'h33 || commit_dest !== 32'h63) begin bad++; $display("FAIL stray_real_wb got=%h/%h exp=33/63", commit_value, commit_dest); end
      $display("test_stray_wb: slot3 value=%h dest=%h", commit_value, commit_dest);
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(32'h40 + 32'(i));
      do_wb(3'd0, 32'h77, 1'b1);
      total++; if (commit_mispredict !== 1'b1) begin bad++; $display("FAIL mp_flag got=%0b exp=1", commit_mispredict); end
      alloc_valid  = 1'b1;
      alloc_dest   = 32'h50;
      commit_ready = 1'b1;
      tick();
      alloc_valid  = 1'b0;
      commit_ready = 1'b0;
`ifdef QU_ROB_FLUSH_EN
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL mp_flush got=%0b exp=1", flush); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mp_count got=%0d exp=0", count); end
      total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL mp_tail got=%0d exp=0", alloc_addr); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL mp_flush_pulse got=%0b exp=0", flush); end
`else
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL mp_noflush got=%0b exp=0", flush); end
      total++; if (count !== 4'd4) begin bad++; $display("FAIL mp_count got=%0d exp=4", count); end
      total++; if (alloc_addr !== 3'd5) begin bad++; $display("FAIL mp_tail got=%0d exp=5", alloc_addr); end
`endif
      $display("test_mispredict: flush=%0b count=%0d tail=%0d", flush, count, alloc_addr);
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) do_alloc(32'h80 + 32'(i));
      do_wb(3'd0, 32'h88, 1'b0);
      alloc_valid = 1'b1;
      alloc_dest  = 32'h90;
      rstn        = 1'b0;
      tick();
      alloc_valid = 1'b0;
      rstn        = 1'b1;
      total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
      total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL mid_tail got=%0d exp=0", alloc_addr); end
      total++; if (commit_valid !== 1'b0 || commit_value !== 32'h0) begin bad++; $display("FAIL mid_commit got=%0b/%h exp=0/0", commit_valid, commit_value); end
      $display("test_reset_mid: count=%0d tail=%0d", count, alloc_addr);
   endtask

   initial begin
      idle_inputs();
      rstn = 1'b0;
      test_reset();
      test_fill_wrap();
      test_backpressure();
      test_alloc_commit();
      test_stray_wb();
      test_mispredict();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
